mmb_burst_splitter: RTL

//  Splits each MemoryMapped burst (mmb) into sub-bursts that never cross a 2**PGWIDTH-word

---
 rtl/mmb_burst_splitter.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/mmb_burst_splitter.sv
// rtl/mmb_burst_splitter.sv - splits mmb bursts into sub-bursts that stay inside one page
// First beat passes through with zero latency; later sub-bursts come from the registered cursor.
module mmb_burst_splitter #(
   parameter int AWIDTH  = 8,
   parameter int DWIDTH  = 8,
   parameter int BWIDTH  = 4,
   parameter int PGWIDTH = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [AWIDTH-1:0] s_addr,
   input  logic [BWIDTH-1:0] s_bcnt,
   input  logic              s_wreq,
   input  logic [DWIDTH-1:0] s_wdat,
   input  logic              s_rreq,
   output logic [DWIDTH-1:0] s_rdat,
   output logic              s_rval,
   output logic              s_busy,
   output logic [AWIDTH-1:0] m_addr,
   output logic [BWIDTH-1:0] m_bcnt,
   output logic              m_wreq,
   output logic [DWIDTH-1:0] m_wdat,
   output logic              m_rreq,
   input  logic [DWIDTH-1:0] m_rdat,
   input  logic              m_rval,
   input  logic              m_busy
);

   localparam int CW = BWIDTH + 1;
   localparam logic [CW-1:0] ONE  = CW'(1);
   localparam logic [CW-1:0] PAGE = ONE << PGWIDTH;

   typedef enum logic [1:0] {ST_IDLE, ST_WRITE, ST_READ} state_t;

   state_t            state_q, state_d;
   logic [AWIDTH-1:0] sub_addr_q, sub_addr_d;
   logic [BWIDTH-1:0] sub_bcnt_q, sub_bcnt_d;
   logic [CW-1:0]     sub_left_q, sub_left_d;
   logic [CW-1:0]     tot_left_q, tot_left_d;

   // Words left before the page boundary, capped at the remaining burst length.
   function automatic logic [CW-1:0] sub_len(input logic [AWIDTH-1:0] a, input logic [CW-1:0] n);
      logic [CW-1:0] room;
      room = PAGE - {{(CW-PGWIDTH){1'b0}}, a[PGWIDTH-1:0]};
      return (n < room) ? n : room;
   endfunction

   logic [CW-1:0]     len, idle_sub, rd_sub;
   logic              in_idle;
   logic [AWIDTH-1:0] cur_addr, nxt_addr;
   logic [BWIDTH-1:0] cur_bcnt;
   logic [CW-1:0]     cur_left, cur_tot, wr_left, wr_tot, nxt_sub;

   assign len      = CW'(s_bcnt) + ONE;
   assign idle_sub = sub_len(s_addr, len);
   assign rd_sub   = sub_len(sub_addr_q, tot_left_q);
   assign in_idle  = (state_q == ST_IDLE);

   // In IDLE the cursor for the accepted write beat is the live upstream burst.
   assign cur_addr = in_idle ? s_addr : sub_addr_q;
   assign cur_bcnt = in_idle ? BWIDTH'(idle_sub - ONE) : sub_bcnt_q;
   assign cur_left = in_idle ? idle_sub : sub_left_q;
   assign cur_tot  = in_idle ? len : tot_left_q;
   assign wr_left  = cur_left - ONE;
   assign wr_tot   = cur_tot - ONE;
   assign nxt_addr = cur_addr + AWIDTH'(cur_bcnt) + AWIDTH'(1);
   assign nxt_sub  = sub_len(nxt_addr, wr_tot);

   assign m_wdat = s_wdat;
   assign s_rdat = m_rdat;
   assign s_rval = m_rval;

   always_comb begin
      state_d    = state_q;
      sub_addr_d = sub_addr_q;
      sub_bcnt_d = sub_bcnt_q;
      sub_left_d = sub_left_q;
      tot_left_d = tot_left_q;
      m_addr     = s_addr;
      m_bcnt     = BWIDTH'(idle_sub - ONE);
      m_wreq     = 1'b0;
      m_rreq     = 1'b0;
      s_busy     = 1'b1;

      case (state_q)
         ST_IDLE: begin
            m_wreq = s_wreq;
            m_rreq = s_rreq & ~s_wreq;
            s_busy = m_busy;
            if (s_rreq && !s_wreq && !m_busy && (len != idle_sub)) begin
               sub_addr_d = s_addr + AWIDTH'(idle_sub);
               tot_left_d = len - idle_sub;
               state_d    = ST_READ;
            end
         end
         ST_WRITE: begin
            m_addr = sub_addr_q;
            m_bcnt = sub_bcnt_q;
            m_wreq = s_wreq;
            s_busy = m_busy;
         end
         ST_READ: begin
            m_addr = sub_addr_q;
            m_bcnt = BWIDTH'(rd_sub - ONE);
            m_rreq = 1'b1;
            if (!m_busy) begin
               sub_addr_d = sub_addr_q + AWIDTH'(rd_sub);
               tot_left_d = tot_left_q - rd_sub;
               if (tot_left_q == rd_sub) begin
                  state_d = ST_IDLE;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase

      // Write beat bookkeeping is shared by IDLE (first beat) and WRITE.
      if (state_q != ST_READ && s_wreq && !m_busy) begin
         if (wr_tot == '0) begin
            state_d    = ST_IDLE;
            sub_left_d = '0;
            tot_left_d = '0;
         end else begin
            state_d    = ST_WRITE;
            tot_left_d = wr_tot;
            sub_addr_d = cur_addr;
            sub_bcnt_d = cur_bcnt;
            sub_left_d = wr_left;
            if (wr_left == '0) begin
               sub_addr_d = nxt_addr;
               sub_bcnt_d = BWIDTH'(nxt_sub - ONE);
               sub_left_d = nxt_sub;
            end
         end
      end

      if (!reset) begin
         m_wreq = 1'b0;
         m_rreq = 1'b0;
         s_busy = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= ST_IDLE;
         sub_addr_q <= '0;
         sub_bcnt_q <= '0;
         sub_left_q <= '0;
         tot_left_q <= '0;
      end else begin
         state_q    <= state_d;
         sub_addr_q <= sub_addr_d;
         sub_bcnt_q <= sub_bcnt_d;
         sub_left_q <= sub_left_d;
         tot_left_q <= tot_left_d;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         assert (!(s_rreq && (s_wreq || state_q == ST_WRITE)));
      end
   end

endmodule
